// File: rtl/button_array_ctrl.sv
// Multi-channel push-button front end: per channel a 2-flop synchroniser, a
// stability-window debouncer and press / release / long-press event pulses.
module button_array_ctrl #(
    parameter int CHANNELS   = 4,
    parameter int DEBOUNCE   = 500_000,
    parameter int LONG_PRESS = 50_000_000,
    parameter int CNT_W      = 32
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic [CHANNELS-1:0] i_button,
    output logic [CHANNELS-1:0] o_level,
    output logic [CHANNELS-1:0] o_press,
    output logic [CHANNELS-1:0] o_release,
    output logic [CHANNELS-1:0] o_long
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'((LONG_PRESS > 0) ? LONG_PRESS - 1 : 0);
    localparam bit               LONG_EN   = (LONG_PRESS > 0);

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        logic             sync_meta;
        logic             sync;
        logic             level;
        logic             press_p;
        logic             rel_p;
        logic             long_p;
        logic             fired;
        logic [CNT_W-1:0] deb_cnt;
        logic [CNT_W-1:0] hold_cnt;
        logic             accept;

        // The window completes on the last of DEBOUNCE consecutive disagreeing samples.
        assign accept = (sync != level) && (deb_cnt == DEB_LAST);

        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                sync_meta <= 1'b0;
                sync      <= 1'b0;
                level     <= 1'b0;
                deb_cnt   <= '0;
                press_p   <= 1'b0;
                rel_p     <= 1'b0;
            end else begin
                sync_meta <= i_button[ch];
                sync      <= sync_meta;
                press_p   <= 1'b0;
                rel_p     <= 1'b0;
                if (sync == level) begin
                    deb_cnt <= '0;
                end else if (accept) begin
                    level   <= sync;
                    deb_cnt <= '0;
                    press_p <= sync;
                    rel_p   <= ~sync;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end
        end

        // The hold count runs from the cycle after the press; a press is always
        // accepted while the old level is 0, which is what rearms the counter.
        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                hold_cnt <= '0;
                fired    <= 1'b0;
                long_p   <= 1'b0;
            end else begin
                long_p <= 1'b0;
                if (!level) begin
                    hold_cnt <= '0;
                    fired    <= 1'b0;
                end else if (LONG_EN && !fired) begin
                    if (hold_cnt == LONG_LAST) begin
                        long_p <= 1'b1;
                        fired  <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
            end
        end

        assign o_level[ch]   = level;
        assign o_press[ch]   = press_p;
        assign o_release[ch] = rel_p;
        assign o_long[ch]    = long_p;
    end

endmodule

// File: tb/tb_button_array_ctrl.sv
// Self-checking bench for button_array_ctrl: directed scenarios plus random
// button activity, compared against a run-length / timestamp reference model.
module tb_button_array_ctrl;

    localparam int CH = 4;
    localparam int DEB = 4;
    localparam int LP = 10;

    logic          i_clk = 1'b0;
    logic          i_reset_n = 1'b0;
    logic [CH-1:0] i_button = '0;
    logic [CH-1:0] o_level, o_press, o_release, o_long;

    int vectors = 0;
    int miscompares = 0;

    button_array_ctrl #(.CHANNELS(CH), .DEBOUNCE(DEB), .LONG_PRESS(LP), .CNT_W(32)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_button(i_button),
        .o_level(o_level), .o_press(o_press), .o_release(o_release), .o_long(o_long)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: a level is accepted once DEB identical synchronised
    // samples in a row disagree with it; long press is timestamp arithmetic.
    int       cyc;
    bit       s1 [CH];
    bit       s2 [CH];
    bit       prev_v [CH];
    int       run_len [CH];
    bit       m_level [CH];
    int       press_cyc [CH];
    logic [CH-1:0] exp_level, exp_press, exp_release, exp_long;

    task automatic model_reset();
        cyc = 0;
        for (int c = 0; c < CH; c++) begin
            s1[c] = 0; s2[c] = 0; prev_v[c] = 0; run_len[c] = 0;
            m_level[c] = 0; press_cyc[c] = -1;
        end
        exp_level = '0; exp_press = '0; exp_release = '0; exp_long = '0;
    endtask

    task automatic model_step();
        bit v;
        bit acc;
        cyc++;
        for (int c = 0; c < CH; c++) begin
            v = s2[c];
            run_len[c] = (v == prev_v[c]) ? run_len[c] + 1 : 1;
            prev_v[c] = v;
            acc = (v != m_level[c]) && (run_len[c] >= DEB);
            exp_long[c] = (LP > 0) && (press_cyc[c] >= 0) && (cyc - press_cyc[c] == LP);
            exp_press[c] = acc && v;
            exp_release[c] = acc && !v;
            if (acc) begin
                m_level[c] = v;
                press_cyc[c] = v ? cyc : -1;
            end
            exp_level[c] = m_level[c];
            s2[c] = s1[c];
            s1[c] = i_button[c];
        end
    endtask

    task automatic cycle();
        @(posedge i_clk);
        if (i_reset_n) model_step();
        else model_reset();
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        vectors++;
        if ({o_level, o_press, o_release, o_long} !== 16'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_hold: got %h expected 0000", {o_level, o_press, o_release, o_long});
        end
        @(negedge i_clk);
        i_reset_n = 1'b1;
        i_button = 4'b0001;
        for (int k = 0; k < 11; k++) begin
            if (k == 8) i_button = 4'b0011;
            cycle();
            vectors++;
            if ({o_level, o_press, o_release, o_long} !== {exp_level, exp_press, exp_release, exp_long}) begin
                miscompares++;
                $display("[TB] FAIL reset_pre k=%0d: got %h expected %h", k,
                         {o_level, o_press, o_release, o_long}, {exp_level, exp_press, exp_release, exp_long});
            end
        end
        #2 i_reset_n = 1'b0;
        #1;
        vectors++;
        if ({o_level, o_press, o_release, o_long} !== 16'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_async: got %h expected 0000", {o_level, o_press, o_release, o_long});
        end
        model_reset();
        i_button = 4'b0000;
        cycle();
        i_reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cycle();
            vectors++;
            if ({o_level, o_press, o_release, o_long} !== 16'h0 ||
                {exp_level, exp_press, exp_release, exp_long} !== 16'h0) begin
                miscompares++;
                $display("[TB] FAIL reset_quiet k=%0d: got %h expected 0000", k, {o_level, o_press, o_release, o_long});
            end
        end
    endtask

    task automatic test_clean_press();
        i_button = 4'b0001;
        for (int k = 1; k <= 7; k++) begin
            cycle();
            vectors++;
            if ({o_level, o_press, o_release, o_long} !== {exp_level, exp_press, exp_release, exp_long}) begin
                miscompares++;
                $display("[TB] FAIL clean_model k=%0d: got %h expected %h", k,
                         {o_level, o_press, o_release, o_long}, {exp_level, exp_press, exp_release, exp_long});
            end
            if (k == 6) begin
                vectors++;
                if (o_press !== 4'b0001 || o_level !== 4'b0001) begin
                    miscompares++;
                    $display("[TB] FAIL clean_edge5: got press=%b level=%b expected 0001/0001", o_press, o_level);
                end
            end
            if (k == 7) begin
                vectors++;
                if (o_press !== 4'b0000) begin
                    miscompares++;
                    $display("[TB] FAIL clean_edge6: got press=%b expected 0000", o_press);
                end
            end
        end
        i_button = 4'b0000;
        for (int k = 0; k < 12; k++) begin
            cycle();
            vectors++;
            if ({o_level, o_press, o_release, o_long} !== {exp_level, exp_press, exp_release, exp_long}) begin
                miscompares++;
                $display("[TB] FAIL clean_release k=%0d: got %h expected %h", k,
                         {o_level, o_press, o_release, o_long}, {exp_level, exp_press, exp_release, exp_long});
            end
        end
    endtask

    task automatic test_bounce();
        bit pat [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        int npress = 0;
        int first = -1;
        for (int k = 0; k < 14; k++) begin
            i_button[2] = (k < 8) ? pat[k] : 1'b1;
            cycle();
            vectors++;
            if ({o_level, o_press, o_release, o_long} !== {exp_level, exp_press, exp_release, exp_long}) begin
                miscompares++;
                $display("[TB] FAIL bounce_model k=%0d: got %h expected %h", k,
                         {o_level, o_press, o_release, o_long}, {exp_level, exp_press, exp_release, exp_long});
            end
            if (o_press[2]) begin
                npress++;
                if (first < 0) first = k;
            end
        end
        vectors++;
        if (npress != 1 || first != 9) begin
            miscompares++;
            $display("[TB] FAIL bounce_timing: got %0d presses first at %0d expected 1 at 9", npress, first);
        end
        i_button[2] = 1'b0;
        for (int k = 0; k < 12; k++) cycle();
    endtask

    task automatic test_long_press();
        int press_k = -1, long_k = -1, rel_k = -1, nlong = 0;
        for (int k = 0; k < 46; k++) begin
            i_button[1] = (k < 30);
            cycle();
            vectors++;
            if ({o_level, o_press, o_release, o_long} !== {exp_level, exp_press, exp_release, exp_long}) begin
                miscompares++;
                $display("[TB] FAIL long_model k=%0d: got %h expected %h", k,
                         {o_level, o_press, o_release, o_long}, {exp_level, exp_press, exp_release, exp_long});
            end
            if (o_press[1]) press_k = k;
            if (o_long[1]) begin nlong++; long_k = k; end
            if (o_release[1]) rel_k = k;
        end
        vectors++;
        if (press_k != 5 || nlong != 1 || long_k - press_k != LP || rel_k != 30 + DEB + 1) begin
            miscompares++;
            $display("[TB] FAIL long_timing: got press=%0d long=%0d(x%0d) rel=%0d expected 5 15(x1) 35",
                     press_k, long_k, nlong, rel_k);
        end
    endtask

    task automatic test_short_press();
        int press_k = -1, rel_k = -1, nlong = 0, npress = 0, nrel = 0;
        for (int k = 0; k < 26; k++) begin
            i_button[3] = (k < 8);
            cycle();
            vectors++;
            if ({o_level, o_press, o_release, o_long} !== {exp_level, exp_press, exp_release, exp_long}) begin
                miscompares++;
                $display("[TB] FAIL short_model k=%0d: got %h expected %h", k,
                         {o_level, o_press, o_release, o_long}, {exp_level, exp_press, exp_release, exp_long});
            end
            if (o_press[3]) begin npress++; press_k = k; end
            if (o_release[3]) begin nrel++; rel_k = k; end
            if (o_long[3]) nlong++;
        end
        vectors++;
        if (npress != 1 || nrel != 1 || nlong != 0 || rel_k - press_k != 8) begin
            miscompares++;
            $display("[TB] FAIL short_events: got p=%0d r=%0d l=%0d held=%0d expected 1 1 0 8",
                     npress, nrel, nlong, rel_k - press_k);
        end
    endtask

    task automatic test_simultaneous();
        int nev = 0;
        i_button = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            cycle();
            vectors++;
            if ({o_level, o_press, o_release, o_long} !== {exp_level, exp_press, exp_release, exp_long}) begin
                miscompares++;
                $display("[TB] FAIL simul_model k=%0d: got %h expected %h", k,
                         {o_level, o_press, o_release, o_long}, {exp_level, exp_press, exp_release, exp_long});
            end
            if (o_press != 4'b0000) nev++;
            if (k == 5) begin
                vectors++;
                if (o_press !== 4'b1111) begin
                    miscompares++;
                    $display("[TB] FAIL simul_press: got %b expected 1111", o_press);
                end
            end
        end
        i_button = 4'b0101;
        for (int k = 0; k < 15; k++) begin
            cycle();
            vectors++;
            if ({o_level, o_press, o_release, o_long} !== {exp_level, exp_press, exp_release, exp_long}) begin
                miscompares++;
                $display("[TB] FAIL simul_model2 k=%0d: got %h expected %h", k,
                         {o_level, o_press, o_release, o_long}, {exp_level, exp_press, exp_release, exp_long});
            end
            if (o_release != 4'b0000) nev++;
            if (k == 5) begin
                vectors++;
                if (o_release !== 4'b1010) begin
                    miscompares++;
                    $display("[TB] FAIL simul_release: got %b expected 1010", o_release);
                end
            end
        end
        vectors++;
        if (nev != 2) begin
            miscompares++;
            $display("[TB] FAIL simul_single: got %0d event cycles expected 2", nev);
        end
        i_button = 4'b0000;
        for (int k = 0; k < 12; k++) cycle();
    endtask

    task automatic test_random();
        int rate;
        for (int k = 0; k < 900; k++) begin
            rate = (k < 300) ? 3 : 25;
            for (int c = 0; c < CH; c++)
                if ($urandom_range(rate - 1, 0) == 0) i_button[c] = ~i_button[c];
            if (k == 450) begin
                #3 i_reset_n = 1'b0;
                #1 model_reset();
            end
            if (k == 453) i_reset_n = 1'b1;
            cycle();
            vectors++;
            if ({o_level, o_press, o_release, o_long} !== {exp_level, exp_press, exp_release, exp_long}) begin
                miscompares++;
                $display("[TB] FAIL random k=%0d: got %h expected %h", k,
                         {o_level, o_press, o_release, o_long}, {exp_level, exp_press, exp_release, exp_long});
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge i_clk);
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_short_press();
        test_simultaneous();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/button_array_ctrl.md
# button_array_ctrl

Parametrised multi-channel debounced push-button front end. It sits between raw board buttons and the FSM logic. For each channel it synchronises the raw input, debounces it with a configurable stability window, and produces a clean level plus single-cycle press, release and long-press event pulses. All channels are independent and identical.

## Interface

- CHANNELS, 4, number of independent button channels (≥1)
- DEBOUNCE, 500_000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz; ≥1)
- LONG_PRESS, 50_000_000, cycles the debounced level must stay high after a press before o_long fires (1 s at 50 MHz); 0 disables o_long
- CNT_W, 32, width of the per-channel debounce and hold counters; must hold max(DEBOUNCE, LONG_PRESS)

- i_clk  in  1  system clock, all logic on rising edge
- i_reset_n  in  1  asynchronous active-low reset
- i_button  in  CHANNELS  raw button inputs, 1 = pushed, asynchronous to i_clk
- o_level  out  CHANNELS  debounced button level, 1 = pushed
- o_press  out  CHANNELS  1-cycle pulse on an accepted released→pushed change
- o_release  out  CHANNELS  1-cycle pulse on an accepted pushed→released change
- o_long  out  CHANNELS  1-cycle pulse once per press after LONG_PRESS cycles held

## Operation

- Reset (i_reset_n = 0, asynchronous): synchroniser flops, o_level, all pulses and all counters go to 0 immediately and stay 0 until release.
- Synchroniser: 2-flop chain per channel. Only the second flop (sync) feeds the logic.
- Debounce, per channel, evaluated each cycle:
  - sync == o_level: debounce counter ← 0.
  - sync != o_level and counter < DEBOUNCE-1: counter +1.
  - sync != o_level and counter == DEBOUNCE-1: o_level ← sync, counter ← 0, assert o_press (new level 1) or o_release (new level 0) for that one cycle.
  - Any single sample equal to o_level restarts the window from 0. The count is never carried over.
- Long press, per channel, with a hold counter and a fired flag:
  - On the edge where o_press asserts: hold counter ← 0, fired ← 0.
  - While o_level = 1 and fired = 0: hold counter +1. When it reaches LONG_PRESS-1, assert o_long for one cycle and set fired ← 1. The counter then stops and does not wrap.
  - While o_level = 0: hold counter ← 0, fired ← 0.
  - Release after a long press still produces o_release.
  - LONG_PRESS = 0: o_long is held at 0.
- Channels never interact. Simultaneous events on several channels are all reported in the same cycle.
- A level already pushed when reset deasserts is reported as a normal press after the debounce window.

## Timing

- Latency: raw change set up before rising edge E0 gives o_level and o_press/o_release on edge E0 + DEBOUNCE + 1, i.e. DEBOUNCE + 2 edges counting E0.
- o_press/o_release are registered and coincide with the o_level transition cycle. Each is exactly 1 cycle wide.
- o_long asserts exactly LONG_PRESS cycles after the o_press cycle.
- No event pulse can occur in the first 2 cycles after reset release.
- Reset asserted mid-debounce or mid-hold discards the partial count. No pulse is generated by the reset itself.

## Test plan

Use CHANNELS=4, DEBOUNCE=4, LONG_PRESS=10.

- Reset: drive i_reset_n=0 asynchronously mid-cycle with channel 1 mid-count → all outputs 0 before the next edge. Release with i_button=4'b0000 → outputs stay 0 for 20 cycles.
- Clean press: i_button[0] 0→1 before edge E0 and held → o_level[0]=1 and o_press[0]=1 at edge E0+5. o_press[0] is low again at E0+6. Other channels stay 0.
- Bounce: i_button[2] sequence 1,1,1,0,1,1,1,1 → no o_press during the first burst. o_press[2] fires 4 accepted cycles after the final 0→1 sample reaches sync.
- Long press: hold i_button[1]=1 for 30 cycles → o_press[1], then o_long[1] exactly 10 cycles later, once only. On release, o_release[1] fires at DEBOUNCE+2 edges after the falling edge.
- Short press: hold i_button[3] so o_level[3] stays high 8 cycles → o_press[3] then o_release[3], no o_long[3].
- Simultaneous channels: i_button 4'b0000→4'b1111 on one edge → o_press=4'b1111 in a single cycle. Later 4'b1111→4'b0101 → o_release=4'b1010 in a single cycle.
